// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - slew-limited motor PWM driver fed by one-hot level selects
// Duty ramps 1 % per SLEW_PERIODS PWM periods; multi-hot selects latch a fault that forces the output off.
module motor_pwm_driver #(
  parameter int CLK_DIV      = 10,
  parameter int SLEW_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sel_30,
  input  logic       sel_50,
  input  logic       sel_100,
  input  logic       fault_clr,
  output logic       pwm_out,
  output logic [6:0] duty,
  output logic       at_target,
  output logic       period_start,
  output logic       fault,
  output logic [2:0] state
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (SLEW_PERIODS > 1) ? $clog2(SLEW_PERIODS) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD      = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        st, st_nx;
  logic [PW-1:0] presc;
  logic [6:0]    cnt;
  logic [SW-1:0] slew, slew_nx;
  logic [6:0]    target, duty_nx;
  logic [1:0]    nsel;
  logic          illegal, presc_wrap, boundary;

  assign nsel       = {1'b0, sel_30} + {1'b0, sel_50} + {1'b0, sel_100};
  assign illegal    = nsel[1];
  assign presc_wrap = (presc == PW'(CLK_DIV - 1));
  assign boundary   = presc_wrap && (cnt == 7'd99);

  always_comb begin
    target = 7'd0;
    if (en && !illegal) begin
      if (sel_30)       target = 7'd30;
      else if (sel_50)  target = 7'd50;
      else if (sel_100) target = 7'd100;
    end
  end

  // Duty only moves at a period boundary so no runt pulse is ever produced.
  always_comb begin
    duty_nx = duty;
    slew_nx = slew;
    if (duty == target) begin
      slew_nx = '0;
    end else if (boundary) begin
      if (slew == SW'(SLEW_PERIODS - 1)) begin
        slew_nx = '0;
        duty_nx = (duty < target) ? duty + 7'd1 : duty - 7'd1;
      end else begin
        slew_nx = slew + 1'b1;
      end
    end
  end

  always_comb begin
    st_nx = HOLD;
    if (duty_nx == 7'd0 && target == 7'd0) st_nx = IDLE;
    else if (duty_nx < target)             st_nx = RAMP_UP;
    else if (duty_nx > target)             st_nx = RAMP_DOWN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc        <= '0;
      cnt          <= '0;
      slew         <= '0;
      duty         <= '0;
      st           <= IDLE;
      fault        <= 1'b0;
      at_target    <= 1'b1;
      period_start <= 1'b0;
    end else begin
      presc        <= presc_wrap ? '0 : presc + 1'b1;
      period_start <= boundary;
      if (presc_wrap) cnt <= (cnt == 7'd99) ? 7'd0 : cnt + 7'd1;

      if (illegal) begin
        st        <= FAULT;
        fault     <= 1'b1;
        duty      <= '0;
        slew      <= '0;
        at_target <= 1'b0;
      end else if (st == FAULT) begin
        if (fault_clr) begin
          st        <= IDLE;
          fault     <= 1'b0;
          duty      <= '0;
          slew      <= '0;
          at_target <= (target == 7'd0);
        end
      end else begin
        duty      <= duty_nx;
        slew      <= slew_nx;
        st        <= st_nx;
        at_target <= (duty_nx == target);
      end
    end
  end

  assign pwm_out = (cnt < duty) && (st != FAULT);
  assign state   = st;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - self-checking bench for motor_pwm_driver
// Vector table for the scripted scenarios plus random stimulus against a period-level model.
module tb_motor_pwm_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, sel_30 = 1'b0, sel_50 = 1'b0, sel_100 = 1'b0, fault_clr = 1'b0;
  logic       pwm_out, at_target, period_start, fault;
  logic [6:0] duty;
  logic [2:0] state;

  always #5 clk = ~clk;

  motor_pwm_driver #(.CLK_DIV(2), .SLEW_PERIODS(1)) dut (
    .clk(clk), .reset(reset), .en(en), .sel_30(sel_30), .sel_50(sel_50),
    .sel_100(sel_100), .fault_clr(fault_clr), .pwm_out(pwm_out), .duty(duty),
    .at_target(at_target), .period_start(period_start), .fault(fault), .state(state)
  );

  int passed = 0;
  int total  = 0;

  // Model: position within a 200-clk period plus applied duty; 1 % step per period.
  int m_phase, m_duty, m_state;
  bit m_fault, m_at, m_ps;

  function automatic void model_reset();
    m_phase = 0; m_duty = 0; m_state = 0;
    m_fault = 0; m_at = 1; m_ps = 0;
  endfunction

  function automatic int model_target();
    if ($countones({sel_30, sel_50, sel_100}) > 1 || !en) return 0;
    if (sel_30)  return 30;
    if (sel_50)  return 50;
    if (sel_100) return 100;
    return 0;
  endfunction

  function automatic void model_step();
    int tgt;
    bit bad;
    tgt     = model_target();
    bad     = $countones({sel_30, sel_50, sel_100}) > 1;
    m_ps    = (m_phase == 199);
    m_phase = (m_phase + 1) % 200;
    if (bad) begin
      m_fault = 1; m_duty = 0; m_state = 4; m_at = 0;
    end else if (m_fault) begin
      if (fault_clr) begin
        m_fault = 0; m_duty = 0; m_state = 0; m_at = (tgt == 0);
      end
    end else begin
      if (m_ps && m_duty != tgt) m_duty += (m_duty < tgt) ? 1 : -1;
      m_at = (m_duty == tgt);
      if (m_duty == 0 && tgt == 0) m_state = 0;
      else if (m_duty == tgt)      m_state = 2;
      else if (m_duty < tgt)       m_state = 1;
      else                         m_state = 3;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_all();
    chk("duty", int'(duty), m_duty);
    chk("state", int'(state), m_state);
    chk("fault", int'(fault), int'(m_fault));
    chk("at_target", int'(at_target), int'(m_at));
    chk("period_start", int'(period_start), int'(m_ps));
    chk("pwm_out", int'(pwm_out), int'(((m_phase / 2) < m_duty) && !m_fault));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input bit e, input bit a, input bit b, input bit c, input bit clr);
    en = e; sel_30 = a; sel_50 = b; sel_100 = c; fault_clr = clr;
  endtask

  typedef struct {
    bit en, s30, s50, s100, clr;
    int ncyc;
    int e_state, e_duty, e_fault, e_at;
    int e_high;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int first_ps, hi, guard, mode;

    vecs[0] = '{1, 1, 0, 0, 0,  7000, 2,  30, 0, 1,  60};
    vecs[1] = '{1, 0, 0, 1, 0, 15000, 2, 100, 0, 1, 200};
    vecs[2] = '{1, 0, 1, 0, 0, 11000, 2,  50, 0, 1,  -1};
    vecs[3] = '{1, 1, 1, 0, 0,     3, 4,   0, 1, 0,   0};
    vecs[4] = '{1, 1, 1, 0, 1,     5, 4,   0, 1, 0,  -1};
    vecs[5] = '{1, 0, 1, 0, 1,     1, 0,   0, 0, 0,  -1};
    vecs[6] = '{1, 0, 1, 0, 0, 11000, 2,  50, 0, 1,  -1};
    vecs[7] = '{0, 0, 1, 0, 0, 11000, 0,   0, 0, 1,   0};

    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b0;

    first_ps = -1;
    for (int k = 1; k <= 400; k++) begin
      cyc();
      if (period_start && first_ps < 0) first_ps = k;
    end
    chk("first_period_start_clk", first_ps, 200);

    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].en, vecs[i].s30, vecs[i].s50, vecs[i].s100, vecs[i].clr);
      repeat (vecs[i].ncyc) cyc();
      chk($sformatf("vec%0d_state", i), int'(state), vecs[i].e_state);
      chk($sformatf("vec%0d_duty", i), int'(duty), vecs[i].e_duty);
      chk($sformatf("vec%0d_fault", i), int'(fault), vecs[i].e_fault);
      chk($sformatf("vec%0d_at_target", i), int'(at_target), vecs[i].e_at);
      if (vecs[i].e_high >= 0) begin
        hi = 0;
        repeat (200) begin cyc(); hi += int'(pwm_out); end
        chk($sformatf("vec%0d_high_clks", i), hi, vecs[i].e_high);
      end
    end

    // Asynchronous reset mid-period while ramping at duty 17.
    set_in(1, 1, 0, 0, 0);
    guard = 0;
    while (m_duty != 17 && guard < 5000) begin cyc(); guard++; end
    chk("reach_duty17", m_duty, 17);
    repeat (10) cyc();
    chk("pwm_before_reset", int'(pwm_out), 1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_pwm", int'(pwm_out), 0);
    chk("async_duty", int'(duty), 0);
    chk("async_state", int'(state), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (600) cyc();
    chk("restart_duty", int'(duty), 3);

    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 5);
      case (mode)
        0: set_in(1'($urandom_range(0, 1)), 0, 0, 0, 1'($urandom_range(0, 1)));
        1: set_in(1'($urandom_range(0, 1)), 1, 0, 0, 1'($urandom_range(0, 1)));
        2: set_in(1'($urandom_range(0, 1)), 0, 1, 0, 1'($urandom_range(0, 1)));
        3: set_in(1'($urandom_range(0, 1)), 0, 0, 1, 1'($urandom_range(0, 1)));
        4: set_in(1'($urandom_range(0, 1)), 1, 0, 1, 1'($urandom_range(0, 1)));
        default: set_in(1'($urandom_range(0, 1)), 1, 1, 1, 1'($urandom_range(0, 1)));
      endcase
      repeat ($urandom_range(1, 300)) cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
